// File: rtl/sap_pkg.sv
// Shared types and widths for the accumulator transmit port.
package sap_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int TMR_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } tx_state_t;

  function automatic logic [BYTE_W-1:0] first_byte(input logic [WORD_W-1:0] w,
                                                   input logic              msb_first);
    return msb_first ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/acc_tx_timer.sv
// Wait-cycle counter for a presented byte; flags the cycle whose increment reaches LIMIT.
module acc_tx_timer
  import sap_pkg::*;
#(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Terminal fires on the edge that would bring the count to LIMIT.
  assign o_tc = i_inc && (r_count == LAST);

endmodule

// File: rtl/acc_tx_port.sv
// Sources the accumulator to an 8-bit valid/ready device and onto the internal bus.
// Optional tx_parity output enabled by defining ACC_TX_PARITY_EN.
module acc_tx_port
  import sap_pkg::*;
#(
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] aout,
  input  logic              acc_out,
  input  logic              out_start,
  input  logic              out_lower,
  output logic [WORD_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              busy,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_err
`ifdef ACC_TX_PARITY_EN
  ,
  output logic              tx_parity
`endif
);

  tx_state_t         r_state;
  logic [WORD_W-1:0] r_snap;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_busy;
  logic              r_tx_err;

  logic              w_hs;
  logic              w_tc;
  logic [BYTE_W-1:0] w_second;
  logic [BYTE_W-1:0] w_data_nxt;

  assign bus_oe  = acc_out;
  assign bus_out = acc_out ? aout : '0;

  assign w_hs     = r_tx_valid && tx_ready;
  assign w_second = MSB_FIRST ? r_snap[7:0] : r_snap[15:8];

  generate
    if (TIMEOUT > 0) begin : g_timer
      acc_tx_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_hs || !r_tx_valid),
        .i_inc   (r_tx_valid && !tx_ready),
        .o_tc    (w_tc)
      );
    end else begin : g_no_timer
      assign w_tc = 1'b0;
    end
  endgenerate

  // Next byte on the wire; shared by tx_data and its parity so both update together.
  always_comb begin
    w_data_nxt = r_tx_data;
    case (r_state)
      IDLE: begin
        if (out_start)      w_data_nxt = first_byte(aout, MSB_FIRST);
        else if (out_lower) w_data_nxt = aout[7:0];
      end
      SEND_A: begin
        if (w_hs) w_data_nxt = w_second;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_snap     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      r_tx_data <= w_data_nxt;
      case (r_state)
        IDLE: begin
          if (out_start) begin
            r_snap     <= aout;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= SEND_A;
          end else if (out_lower) begin
            r_snap     <= {8'h00, aout[7:0]};
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= SEND_B;
          end
        end
        SEND_A, SEND_B: begin
          if (w_hs) begin
            if (r_state == SEND_A) begin
              r_state <= SEND_B;
            end else begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
            end
          end else if (w_tc) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_err   <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ACC_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ^w_data_nxt;
  end

  assign tx_parity = r_parity;
`endif

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign tx_err   = r_tx_err;

endmodule

// File: tb/tb_acc_tx_port.sv
// Bench for acc_tx_port: instance A (MSB first, no timeout), instance B (LSB first, TIMEOUT=4).
module tb_acc_tx_port;

  localparam int TO_B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a_aout, a_bus_out, b_aout, b_bus_out;
  logic        a_acc_out, a_start, a_lower, a_ready, a_bus_oe, a_busy, a_valid, a_err;
  logic        b_acc_out, b_start, b_lower, b_ready, b_bus_oe, b_busy, b_valid, b_err;
  logic [7:0]  a_data, b_data;
`ifdef ACC_TX_PARITY_EN
  logic        a_par, b_par;
`endif

  acc_tx_port #(.MSB_FIRST(1'b1), .TIMEOUT(0)) u_a (
    .clk(clk), .rst(rst), .aout(a_aout), .acc_out(a_acc_out),
    .out_start(a_start), .out_lower(a_lower), .bus_out(a_bus_out), .bus_oe(a_bus_oe),
    .busy(a_busy), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready), .tx_err(a_err)
`ifdef ACC_TX_PARITY_EN
    , .tx_parity(a_par)
`endif
  );

  acc_tx_port #(.MSB_FIRST(1'b0), .TIMEOUT(TO_B)) u_b (
    .clk(clk), .rst(rst), .aout(b_aout), .acc_out(b_acc_out),
    .out_start(b_start), .out_lower(b_lower), .bus_out(b_bus_out), .bus_oe(b_bus_oe),
    .busy(b_busy), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready), .tx_err(b_err)
`ifdef ACC_TX_PARITY_EN
    , .tx_parity(b_par)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: pending bytes per instance; a non-empty queue means a byte is on offer.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         wb;
  bit         eb;

  task automatic model_clear();
    qa.delete();
    qb.delete();
    wb = 0;
    eb = 1'b0;
  endtask

  task automatic model_step();
    if (qa.size() == 0) begin
      if (a_start) begin
        qa.push_back(a_aout[15:8]);
        qa.push_back(a_aout[7:0]);
      end else if (a_lower) begin
        qa.push_back(a_aout[7:0]);
      end
    end else if (a_ready) begin
      qa.delete(0);
    end
    if (qb.size() == 0) begin
      wb = 0;
      if (b_start) begin
        qb.push_back(b_aout[7:0]);
        qb.push_back(b_aout[15:8]);
      end else if (b_lower) begin
        qb.push_back(b_aout[7:0]);
      end
    end else if (b_ready) begin
      qb.delete(0);
      wb = 0;
    end else begin
      wb++;
      if (wb == TO_B) begin
        qb.delete();
        wb = 0;
        eb = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {a_aout, a_acc_out, a_start, a_lower, a_ready} = '0;
    {b_aout, b_acc_out, b_start, b_lower, b_ready} = '0;
    model_clear();
    #3;
    n_vec++;
    if ({a_valid, a_busy, a_data, a_err} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_a got v=%b b=%b d=%h e=%b want all 0", a_valid, a_busy, a_data, a_err);
    end
    n_vec++;
    if ({b_valid, b_busy, b_data, b_err} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_b got v=%b b=%b d=%h e=%b want all 0", b_valid, b_busy, b_data, b_err);
    end
`ifdef ACC_TX_PARITY_EN
    n_vec++;
    if ({a_par, b_par} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_parity got %b%b want 00", a_par, b_par);
    end
`endif
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    n_vec++;
    if ({a_valid, a_busy, b_valid, b_busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_after_reset got %b%b%b%b want 0000", a_valid, a_busy, b_valid, b_busy);
    end
  endtask

  task automatic test_full_send();
    logic [31:0] cat = '0;
    int n = 0, nb = 0;
    a_aout = 16'hA55A; a_ready = 1'b1; a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (a_valid) begin cat = {cat[23:0], a_data}; n++; end
      if (a_busy) nb++;
      step();
    end
    n_vec++;
    if (n != 2 || cat[15:0] !== 16'hA55A) begin
      n_err++;
      $display("FAIL full_send bytes got n=%0d %h want 2 a55a", n, cat[15:0]);
    end
    n_vec++;
    if (nb != 2) begin
      n_err++;
      $display("FAIL full_send_busy got %0d cycles want 2", nb);
    end
  endtask

  task automatic test_lower();
    logic [31:0] cat = '0;
    int n = 0, nb = 0;
    a_aout = 16'h12C3; a_ready = 1'b1; a_lower = 1'b1;
    step();
    a_lower = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a_valid) begin cat = {cat[23:0], a_data}; n++; end
      if (a_busy) nb++;
      step();
    end
    n_vec++;
    if (n != 1 || cat[7:0] !== 8'hC3 || nb != 1) begin
      n_err++;
      $display("FAIL lower_send got n=%0d %h busy=%0d want 1 c3 1", n, cat[7:0], nb);
    end
    cat = '0; n = 0;
    a_start = 1'b1; a_lower = 1'b1;
    step();
    a_start = 1'b0; a_lower = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a_valid) begin cat = {cat[23:0], a_data}; n++; end
      step();
    end
    n_vec++;
    if (n != 2 || cat[15:0] !== 16'h12C3) begin
      n_err++;
      $display("FAIL start_wins got n=%0d %h want 2 12c3", n, cat[15:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] cat = '0;
    int n = 0, bad = 0;
    a_aout = 16'hBEEF; a_ready = 1'b0; a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (a_valid !== 1'b1 || a_data !== 8'hBE || a_busy !== 1'b1) bad++;
      a_aout = 16'hFFFF;
      a_start = (i == 2);
      step();
    end
    a_start = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold_stable got %0d unstable cycles want 0", bad);
    end
    a_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (a_valid) begin cat = {cat[23:0], a_data}; n++; end
      step();
    end
    n_vec++;
    if (n != 2 || cat[15:0] !== 16'hBEEF) begin
      n_err++;
      $display("FAIL isolation got n=%0d %h want 2 beef", n, cat[15:0]);
    end
  endtask

  task automatic test_timeout();
    int nv = 0;
    logic [31:0] cat = '0;
    int n = 0;
    b_aout = 16'h1234; b_ready = 1'b0; b_start = 1'b1;
    step();
    b_start = 1'b0;
    n_vec++;
    if (b_valid !== 1'b1 || b_data !== 8'h34) begin
      n_err++;
      $display("FAIL lsb_first got v=%b d=%h want 1 34", b_valid, b_data);
    end
    repeat (3) step();
    b_ready = 1'b1;
    step();
    n_vec++;
    if (b_err !== 1'b0 || b_valid !== 1'b1 || b_data !== 8'h12) begin
      n_err++;
      $display("FAIL late_handshake got e=%b v=%b d=%h want 0 1 12", b_err, b_valid, b_data);
    end
    step();
    b_aout = 16'hABCD; b_ready = 1'b0; b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b_valid) nv++;
      step();
    end
    n_vec++;
    if (nv != TO_B || b_err !== 1'b1 || b_busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout got valid_cycles=%0d e=%b busy=%b want 4 1 0", nv, b_err, b_busy);
    end
    b_aout = 16'h5678; b_ready = 1'b1; b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (b_valid) begin cat = {cat[23:0], b_data}; n++; end
      step();
    end
    n_vec++;
    if (n != 2 || cat[15:0] !== 16'h7856 || b_err !== 1'b1) begin
      n_err++;
      $display("FAIL after_timeout got n=%0d %h e=%b want 2 7856 1", n, cat[15:0], b_err);
    end
  endtask

  task automatic test_reset_mid();
    a_aout = 16'hCAFE; a_ready = 1'b0; a_start = 1'b1;
    step();
    a_start = 1'b0; a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    n_vec++;
    if (a_valid !== 1'b1 || a_data !== 8'hFE) begin
      n_err++;
      $display("FAIL second_byte got v=%b d=%h want 1 fe", a_valid, a_data);
    end
    #2 rst = 1'b1;
    model_clear();
    #1;
    n_vec++;
    if ({a_valid, a_busy, a_data, b_err} !== 11'd0) begin
      n_err++;
      $display("FAIL async_reset got v=%b b=%b d=%h be=%b want all 0", a_valid, a_busy, a_data, b_err);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_vec++;
    if ({a_valid, a_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_mid_reset got %b%b want 00", a_valid, a_busy);
    end
    a_aout = 16'h0102; a_ready = 1'b1; a_start = 1'b1;
    step();
    a_start = 1'b0;
    n_vec++;
    if (a_valid !== 1'b1 || a_data !== 8'h01) begin
      n_err++;
      $display("FAIL restart got v=%b d=%h want 1 01", a_valid, a_data);
    end
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_aout    = 16'($urandom);
      a_start   = ($urandom_range(0, 7) == 0);
      a_lower   = ($urandom_range(0, 7) == 0);
      a_ready   = ($urandom_range(0, 3) != 0);
      a_acc_out = $urandom_range(0, 1) == 1;
      b_aout    = 16'($urandom);
      b_start   = ($urandom_range(0, 5) == 0);
      b_lower   = ($urandom_range(0, 5) == 0);
      b_ready   = ($urandom_range(0, 1) == 1);
      step();
      n_vec++;
      if (a_valid !== (qa.size() != 0) || a_busy !== (qa.size() != 0) ||
          (qa.size() != 0 && a_data !== qa[0])) begin
        n_err++;
        $display("FAIL rand_a cyc %0d got v=%b b=%b d=%h want v=%0d d=%h", i, a_valid, a_busy,
                 a_data, qa.size() != 0, (qa.size() != 0) ? qa[0] : 8'h00);
      end
      n_vec++;
      if (b_valid !== (qb.size() != 0) || b_busy !== (qb.size() != 0) || b_err !== eb ||
          (qb.size() != 0 && b_data !== qb[0])) begin
        n_err++;
        $display("FAIL rand_b cyc %0d got v=%b b=%b d=%h e=%b want v=%0d d=%h e=%b", i, b_valid,
                 b_busy, b_data, b_err, qb.size() != 0, (qb.size() != 0) ? qb[0] : 8'h00, eb);
      end
      n_vec++;
      if (a_bus_oe !== a_acc_out || a_bus_out !== (a_acc_out ? a_aout : 16'h0000)) begin
        n_err++;
        $display("FAIL rand_bus cyc %0d got oe=%b out=%h want oe=%b", i, a_bus_oe, a_bus_out, a_acc_out);
      end
`ifdef ACC_TX_PARITY_EN
      n_vec++;
      if (a_valid && a_par !== ^a_data) begin
        n_err++;
        $display("FAIL rand_parity cyc %0d got %b want %b", i, a_par, ^a_data);
      end
`endif
    end
    {a_start, a_lower, a_acc_out, b_start, b_lower} = '0;
    a_ready = 1'b1; b_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_bus_parity();
    a_aout = 16'h3344; a_ready = 1'b0; a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_acc_out = 1'b1; a_aout = 16'h0F0F;
    #1;
    n_vec++;
    if (a_bus_oe !== 1'b1 || a_bus_out !== 16'h0F0F) begin
      n_err++;
      $display("FAIL bus_drive got oe=%b out=%h want 1 0f0f", a_bus_oe, a_bus_out);
    end
    a_acc_out = 1'b0;
    #1;
    n_vec++;
    if (a_bus_oe !== 1'b0 || a_bus_out !== 16'h0000) begin
      n_err++;
      $display("FAIL bus_idle got oe=%b out=%h want 0 0000", a_bus_oe, a_bus_out);
    end
    a_ready = 1'b1;
    repeat (3) step();
`ifdef ACC_TX_PARITY_EN
    b_aout = 16'h0007; b_ready = 1'b0; b_lower = 1'b1;
    step();
    b_lower = 1'b0;
    n_vec++;
    if (b_data !== 8'h07 || b_par !== 1'b1) begin
      n_err++;
      $display("FAIL parity_07 got d=%h p=%b want 07 1", b_data, b_par);
    end
    b_ready = 1'b1;
    repeat (2) step();
`endif
  endtask

  initial begin
    test_reset();
    test_full_send();
    test_lower();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    test_bus_parity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
